// File: rtl/xor_puf_batch_scheduler.sv
// Batch sequencer for the XOR PUF array: runs a trigger-started series of evaluations,
// keeps the run-0 response and accumulates a per-bit stability mask across runs.
module xor_puf_batch_scheduler #(
  parameter int         WIDTH      = 128,
  parameter logic [7:0] TRIG_CODE  = 8'd3,
  parameter int         GAP_CYCLES = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [7:0]       i_code,
  input  logic [15:0]      i_cnt_val,
  input  logic [7:0]       i_num_runs,
  input  logic [WIDTH-1:0] i_puf_out,
  output logic             o_reset_xor,
  output logic             o_i1_xor,
  output logic             o_i2_xor,
  output logic             o_busy,
  output logic             o_done,
  output logic [7:0]       o_run_cnt,
  output logic [WIDTH-1:0] o_puf_resp,
  output logic [WIDTH-1:0] o_stable_mask,
  output logic [7:0]       o_unstable_cnt
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LATCH   = 3'd1,
    S_ARM     = 3'd2,
    S_EVAL    = 3'd3,
    S_CAPTURE = 3'd4,
    S_GAP     = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES);

  state_t           r_state;
  state_t           w_state_next;
  logic [15:0]      r_cnt_lim;
  logic [7:0]       r_runs_lim;
  logic [15:0]      r_cyc;
  logic [7:0]       r_run_cnt;
  logic [WIDTH-1:0] r_puf_resp;
  logic [WIDTH-1:0] r_mask;
  logic             r_reset_xor;
  logic             r_i1_xor;
  logic             r_i2_xor;
  logic             r_busy;
  logic             r_done;
  logic [7:0]       r_unstable_cnt;
  logic             w_trig;
  logic [7:0]       w_run_cnt_inc;

  function automatic logic [7:0] f_zero_count(input logic [WIDTH-1:0] v);
    logic [7:0] cnt;
    cnt = 8'd0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt = cnt + {7'd0, ~v[i]};
    end
    return cnt;
  endfunction

  assign w_trig        = (i_code == TRIG_CODE);
  assign w_run_cnt_inc = r_run_cnt + 8'd1;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode; DONE is held while the trigger opcode persists so one hold = one batch
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (w_trig) w_state_next = S_LATCH; else w_state_next = S_IDLE;
      S_LATCH:   w_state_next = S_ARM;
      S_ARM:     w_state_next = S_EVAL;
      S_EVAL:    if (r_cyc == r_cnt_lim) w_state_next = S_CAPTURE; else w_state_next = S_EVAL;
      S_CAPTURE: if (w_run_cnt_inc == r_runs_lim) w_state_next = S_DONE; else w_state_next = S_GAP;
      S_GAP:     if (r_cyc == GAP_LAST) w_state_next = S_ARM; else w_state_next = S_GAP;
      S_DONE:    if (w_trig) w_state_next = S_DONE; else w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  // Batch limits, phase counter and result accumulation
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt_lim  <= 16'd1;
      r_runs_lim <= 8'd1;
      r_cyc      <= 16'd0;
      r_run_cnt  <= 8'd0;
      r_puf_resp <= '0;
      r_mask     <= '1;
    end else begin
      case (r_state)
        S_LATCH: begin
          r_cnt_lim  <= (i_cnt_val == 16'd0) ? 16'd1 : i_cnt_val;
          r_runs_lim <= (i_num_runs == 8'd0) ? 8'd1 : i_num_runs;
          r_run_cnt  <= 8'd0;
          r_mask     <= '1;
        end
        S_ARM:  r_cyc <= 16'd1;
        S_EVAL: r_cyc <= r_cyc + 16'd1;
        S_CAPTURE: begin
          r_cyc     <= 16'd1;
          r_run_cnt <= w_run_cnt_inc;
          if (r_run_cnt == 8'd0) begin
            r_puf_resp <= i_puf_out;
          end else begin
            r_mask <= r_mask & ~(i_puf_out ^ r_puf_resp);
          end
        end
        S_GAP:   r_cyc <= r_cyc + 16'd1;
        default: r_cyc <= r_cyc;
      endcase
    end
  end

  // Registered output decode of the current state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_reset_xor    <= 1'b0;
      r_i1_xor       <= 1'b0;
      r_i2_xor       <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_unstable_cnt <= 8'd0;
    end else begin
      r_reset_xor <= (r_state == S_ARM) || (r_state == S_EVAL) || (r_state == S_CAPTURE);
      r_i1_xor    <= (r_state == S_EVAL) || (r_state == S_CAPTURE);
      r_i2_xor    <= (r_state == S_EVAL) || (r_state == S_CAPTURE);
      r_busy      <= (r_state == S_LATCH) || (r_state == S_ARM) || (r_state == S_EVAL) ||
                     (r_state == S_CAPTURE) || (r_state == S_GAP);
      r_done      <= (r_state == S_DONE);
      if (r_state == S_DONE) begin
        r_unstable_cnt <= f_zero_count(r_mask);
      end else begin
        r_unstable_cnt <= r_unstable_cnt;
      end
    end
  end

  assign o_reset_xor    = r_reset_xor;
  assign o_i1_xor       = r_i1_xor;
  assign o_i2_xor       = r_i2_xor;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_run_cnt      = r_run_cnt;
  assign o_puf_resp     = r_puf_resp;
  assign o_stable_mask  = r_mask;
  assign o_unstable_cnt = r_unstable_cnt;

endmodule

// File: tb/tb_xor_puf_batch_scheduler.sv
// Self-checking bench: a schedule-arithmetic model of the batch is compared every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_xor_puf_batch_scheduler;

  localparam int GAP = 4;

  logic         clk;
  logic         i_rst_n;
  logic [7:0]   i_code;
  logic [15:0]  i_cnt_val;
  logic [7:0]   i_num_runs;
  logic [127:0] i_puf;
  logic         o_reset_xor, o_i1_xor, o_i2_xor, o_busy, o_done;
  logic [7:0]   o_run_cnt, o_unstable_cnt;
  logic [127:0] o_puf_resp, o_stable_mask;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // model state
  bit           m_active = 1'b0;
  int           m_t0 = 0;
  int           m_c = 4;
  int           m_r = 3;
  bit           m_drop_set = 1'b0;
  int           m_drop = 0;
  logic [127:0] m_prev_resp = '0;
  int           m_prev_unst = 0;
  logic [127:0] plan [3];
  int           i1_cnt = 0;

  localparam logic [127:0] ALL1 = {128{1'b1}};
  localparam logic [127:0] PA5  = {16{8'hA5}};
  localparam logic [127:0] PDB  = {4{32'hDEADBEEF}};
  localparam logic [127:0] P12  = {4{32'h12345678}};
  localparam logic [127:0] FLIP = {1'b1, 126'd0, 1'b1};

  xor_puf_batch_scheduler #(.WIDTH(128), .TRIG_CODE(8'd3), .GAP_CYCLES(GAP)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_code(i_code), .i_cnt_val(i_cnt_val),
    .i_num_runs(i_num_runs), .i_puf_out(i_puf),
    .o_reset_xor(o_reset_xor), .o_i1_xor(o_i1_xor), .o_i2_xor(o_i2_xor),
    .o_busy(o_busy), .o_done(o_done), .o_run_cnt(o_run_cnt),
    .o_puf_resp(o_puf_resp), .o_stable_mask(o_stable_mask), .o_unstable_cnt(o_unstable_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [127:0] final_mask();
    logic [127:0] mk;
    mk = ALL1;
    for (int j = 1; j < m_r; j++) mk = mk & ~(plan[j] ^ plan[0]);
    return mk;
  endfunction

  // Per-cycle compare against the schedule model
  always @(posedge clk) begin
    int n, m, p, tot, k, pos, e_runs, e_unst;
    logic e_rx, e_i, e_busy, e_done;
    logic [127:0] e_mask, e_resp;
    bit done_ph;
    #1;
    n = cyc - m_t0;
    if (m_active && n >= 1) begin
      p = m_c + 2 + GAP;
      tot = m_r * (m_c + 2) + (m_r - 1) * GAP;
      e_rx = 1'b0; e_i = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_runs = 0;
      done_ph = (n >= 2) && (n - 2 >= tot);
      if (n == 1) begin
        e_busy = 1'b1;
      end else if (done_ph) begin
        e_runs = m_r;
        e_done = !(m_drop_set && cyc >= m_drop + 1);
      end else begin
        m = n - 2;
        e_busy = 1'b1;
        k = m / p;
        pos = m % p;
        e_runs = k + ((pos >= m_c + 1) ? 1 : 0);
        if (pos == 0) e_rx = 1'b1;
        else if (pos <= m_c + 1) begin e_rx = 1'b1; e_i = 1'b1; end
      end
      e_mask = ALL1;
      for (int j = 1; j < e_runs; j++) e_mask = e_mask & ~(plan[j] ^ plan[0]);
      e_resp = (e_runs > 0) ? plan[0] : m_prev_resp;
      e_unst = done_ph ? $countones(~e_mask) : m_prev_unst;
      chk("cyc_reset_xor", 128'(o_reset_xor), 128'(e_rx));
      chk("cyc_i1_xor", 128'(o_i1_xor), 128'(e_i));
      chk("cyc_i2_xor", 128'(o_i2_xor), 128'(e_i));
      chk("cyc_busy", 128'(o_busy), 128'(e_busy));
      chk("cyc_done", 128'(o_done), 128'(e_done));
      chk("cyc_run_cnt", 128'(o_run_cnt), 128'(e_runs));
      chk("cyc_puf_resp", o_puf_resp, e_resp);
      chk("cyc_mask", o_stable_mask, e_mask);
      chk("cyc_unstable", 128'(o_unstable_cnt), 128'(e_unst));
    end
  end

  task automatic step();
    int n, k;
    @(negedge clk);
    n = cyc - m_t0;
    if (!m_active || n < 2) k = 0;
    else k = (n - 2) / (m_c + 2 + GAP);
    if (k > m_r - 1) k = m_r - 1;
    i_puf = plan[k];
    if (m_active && o_i1_xor) i1_cnt++;
  endtask

  task automatic run_to(input int n);
    while (cyc < m_t0 + n) step();
  endtask

  task automatic end_batch();
    i_code = 8'd0;
    m_drop = cyc + 1;
    m_drop_set = 1'b1;
    step(); step(); step();
    m_prev_resp = plan[0];
    m_prev_unst = $countones(~final_mask());
  endtask

  task automatic start_batch(input logic [15:0] c, input logic [7:0] r,
                             input logic [127:0] p0, input logic [127:0] p1, input logic [127:0] p2);
    plan[0] = p0; plan[1] = p1; plan[2] = p2;
    i_cnt_val = c;
    i_num_runs = r;
    m_c = (c == 16'd0) ? 1 : int'(c);
    m_r = (r == 8'd0) ? 1 : int'(r);
    m_drop_set = 1'b0;
    i1_cnt = 0;
    i_code = 8'd3;
    m_t0 = cyc + 1;
    m_active = 1'b1;
  endtask

  initial begin
    plan[0] = PA5; plan[1] = PA5; plan[2] = PA5;
    i_rst_n = 1'b0;
    i_code = 8'd3;
    i_cnt_val = 16'd4;
    i_num_runs = 8'd3;
    i_puf = PA5;

    // reset held with trigger present: nothing moves
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_drives", {125'd0, o_reset_xor, o_i1_xor, o_i2_xor}, 128'd0);
      chk("rst_busy_done", {126'd0, o_busy, o_done}, 128'd0);
      chk("rst_run_cnt", 128'(o_run_cnt), 128'd0);
      chk("rst_resp", o_puf_resp, 128'd0);
      chk("rst_mask", o_stable_mask, ALL1);
      chk("rst_unstable", 128'(o_unstable_cnt), 128'd0);
    end

    // release: first edge samples the held trigger; C=4 R=3 constant A5 pattern
    m_t0 = cyc + 1;
    m_active = 1'b1;
    i1_cnt = 0;
    i_rst_n = 1'b1;
    run_to(1);
    chk("t1_busy_after_latch", 128'(o_busy), 128'd1);
    run_to(27);
    chk("t2_done_e27", 128'(o_done), 128'd0);
    run_to(28);
    chk("t2_done_e28", 128'(o_done), 128'd1);
    run_to(32);
    chk("t2_i1_cycles", 128'(i1_cnt), 128'd15);
    chk("t2_resp", o_puf_resp, PA5);
    chk("t2_mask", o_stable_mask, ALL1);
    chk("t2_unstable", 128'(o_unstable_cnt), 128'd0);
    chk("t2_run_cnt", 128'(o_run_cnt), 128'd3);
    end_batch();

    // zero length / zero runs degrade to a single one-cycle evaluation
    start_batch(16'd0, 8'd0, PDB, PDB, PDB);
    run_to(4);
    chk("t4_done_e4", 128'(o_done), 128'd0);
    run_to(5);
    chk("t4_done_e5", 128'(o_done), 128'd1);
    chk("t4_run_cnt", 128'(o_run_cnt), 128'd1);
    chk("t4_resp", o_puf_resp, PDB);
    end_batch();

    // bits 0 and 127 flip on the last run only
    start_batch(16'd4, 8'd3, PA5, PA5, PA5 ^ FLIP);
    run_to(30);
    chk("t3_mask", o_stable_mask, ~FLIP);
    chk("t3_unstable", 128'(o_unstable_cnt), 128'd2);
    chk("t3_resp", o_puf_resp, PA5);

    // trigger held long after DONE: no rerun
    run_to(80);
    chk("t5_done_held", 128'(o_done), 128'd1);
    chk("t5_busy_held", 128'(o_busy), 128'd0);
    i_code = 8'd0;
    m_drop = cyc + 1;
    m_drop_set = 1'b1;
    step();
    chk("t5_done_drop_edge", 128'(o_done), 128'd1);
    step();
    chk("t5_done_after", 128'(o_done), 128'd0);
    chk("t5_resp_kept", o_puf_resp, PA5);
    chk("t5_mask_kept", o_stable_mask, ~FLIP);
    step();
    m_prev_resp = plan[0];
    m_prev_unst = $countones(~final_mask());
    start_batch(16'd4, 8'd3, P12, P12, P12);
    run_to(1);
    chk("t5_mask_cleared", o_stable_mask, ALL1);
    chk("t5_busy", 128'(o_busy), 128'd1);

    // asynchronous reset in the middle of run 1 evaluation
    run_to(14);
    chk("t6_i1_before", 128'(o_i1_xor), 128'd1);
    m_active = 1'b0;
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("t6_drives_async", {125'd0, o_reset_xor, o_i1_xor, o_i2_xor}, 128'd0);
    chk("t6_busy_async", 128'(o_busy), 128'd0);
    chk("t6_run_cnt", 128'(o_run_cnt), 128'd0);
    chk("t6_resp", o_puf_resp, 128'd0);
    step();
    m_prev_resp = '0;
    m_prev_unst = 0;
    m_drop_set = 1'b0;
    i1_cnt = 0;
    m_t0 = cyc + 1;
    m_active = 1'b1;
    i_rst_n = 1'b1;
    run_to(28);
    chk("t6_done", 128'(o_done), 128'd1);
    chk("t6_run_cnt_done", 128'(o_run_cnt), 128'd3);
    chk("t6_resp_done", o_puf_resp, P12);
    run_to(30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
